// File: rtl/bcd_chain_ctrl.sv
// bcd_chain_ctrl: command sequencer for a multi-digit BCD up/down counter.
// A prescaler divides clk into count ticks while running; carry/borrow
// ripples combinationally across all digits so every digit updates on the
// same edge. sup/inf flag the all-9s <-> all-0s wraps for one cycle.
module bcd_chain_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [4*DIGITS-1:0]   cmd_data,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  dir,
    output logic                  sup,
    output logic                  inf
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LOAD} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          accept;
    logic          tick;
    logic [W-1:0]  inc_val;
    logic [W-1:0]  dec_val;
    logic [W-1:0]  load_val;
    // cup[i]/cdn[i]: every digit below i is 9 (up) / 0 (down), so digit i moves
    logic [DIGITS:0] cup;
    logic [DIGITS:0] cdn;

    assign accept = cmd_valid & cmd_ready;
    assign tick   = (state == S_RUN) && (presc == PW'(PRESCALE - 1));
    assign cup[0] = 1'b1;
    assign cdn[0] = 1'b1;

    // Per-digit next values for increment, decrement and clamped load
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic [3:0] d;
        logic [3:0] ld;
        assign d  = count[4*g +: 4];
        assign ld = cmd_data[4*g +: 4];
        assign cup[g+1] = cup[g] & (d == 4'd9);
        assign cdn[g+1] = cdn[g] & (d == 4'd0);
        assign inc_val[4*g +: 4]  = cup[g] ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
        assign dec_val[4*g +: 4]  = cdn[g] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
        assign load_val[4*g +: 4] = (ld > 4'd9) ? 4'd9 : ld;
    end

    // Control FSM, prescaler and counter; an accepted command beats a tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            presc     <= '0;
            count     <= '0;
            dir       <= 1'b0;
            running   <= 1'b0;
            sup       <= 1'b0;
            inf       <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            sup <= 1'b0;
            inf <= 1'b0;
            if (accept) begin
                presc <= '0;
                case (cmd_op)
                    OP_STOP: begin
                        state   <= S_IDLE;
                        running <= 1'b0;
                    end
                    OP_UP: begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        dir     <= 1'b0;
                    end
                    OP_DOWN: begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        dir     <= 1'b1;
                    end
                    default: begin
                        state     <= S_LOAD;
                        running   <= 1'b0;
                        cmd_ready <= 1'b0;
                        count     <= load_val;
                    end
                endcase
            end else begin
                case (state)
                    S_LOAD: begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end
                    S_RUN: begin
                        if (tick) begin
                            presc <= '0;
                            count <= dir ? dec_val : inc_val;
                            sup   <= ~dir & cup[DIGITS];
                            inf   <= dir & cdn[DIGITS];
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
